// File: rtl/spmv_pkg.sv
// Shared types and constants for the SpMV reduction network.
// Element struct, pad id and ingress FSM states.
package spmv_pkg;

  localparam int DEF_IN_WIDTH = 59;
  localparam int DEF_ID_WIDTH = 13;

  // Reserved id for pad elements; all-ones so it always sorts last.
  localparam logic [DEF_ID_WIDTH-1:0] DEF_PAD_ID = {DEF_ID_WIDTH{1'b1}};

  typedef struct packed {
    logic [DEF_ID_WIDTH-1:0] id;
    logic [DEF_IN_WIDTH-1:0] val;
  } elem_t;

  typedef enum logic {
    EMPTY = 1'b0,
    HALF  = 1'b1
  } state_e;

endpackage

// File: rtl/spmv_pair_sort.sv
// Combinational two-element compare/swap on id (unsigned).
// Equal ids keep arrival order: the first element stays on the low side.
module spmv_pair_sort #(
  parameter int ID_W  = 13,
  parameter int VAL_W = 59
) (
  input  logic [ID_W-1:0]  i_first_id,
  input  logic [VAL_W-1:0] i_first_val,
  input  logic [ID_W-1:0]  i_second_id,
  input  logic [VAL_W-1:0] i_second_val,
  output logic [ID_W-1:0]  o_lo_id,
  output logic [VAL_W-1:0] o_lo_val,
  output logic [ID_W-1:0]  o_hi_id,
  output logic [VAL_W-1:0] o_hi_val
);

  logic w_swap;

  // Strict less-than so a tie never swaps.
  assign w_swap   = i_second_id < i_first_id;
  assign o_lo_id  = w_swap ? i_second_id  : i_first_id;
  assign o_lo_val = w_swap ? i_second_val : i_first_val;
  assign o_hi_id  = w_swap ? i_first_id   : i_second_id;
  assign o_hi_val = w_swap ? i_first_val  : i_second_val;

endmodule

// File: rtl/spmv_network_inject.sv
// Ingress stage of the SpMV reduction network: packs a single element stream
// into id-ordered (a,b) pairs, padding odd-length batches with a PAD_ID element.
module spmv_network_inject
  import spmv_pkg::*;
#(
  parameter int                   IN_WIDTH = DEF_IN_WIDTH,
  parameter int                   ID_WIDTH = DEF_ID_WIDTH,
  parameter logic [ID_WIDTH-1:0]  PAD_ID   = {ID_WIDTH{1'b1}}
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [ID_WIDTH-1:0] s_id,
  input  logic [IN_WIDTH-1:0] s_val,
  input  logic                s_last,
  input  logic                s_valid,
  output logic                s_ready,
  output logic [ID_WIDTH-1:0] a_id,
  output logic [IN_WIDTH-1:0] a_val,
  output logic [ID_WIDTH-1:0] b_id,
  output logic [IN_WIDTH-1:0] b_val,
  output logic                out_valid,
  output logic                out_last,
  input  logic                out_ready,
  output logic                busy,
  output logic                err_pad_id,
  output state_e              dbg_state
);

  // Handshakes: a transfer happens on a rising clk edge where valid && ready;
  // the sender holds its fields stable while valid && !ready, and ready is
  // never derived from the sender's valid or data.

  state_e              r_state;
  state_e              w_next_state;
  logic [ID_WIDTH-1:0] r_hold_id;
  logic [IN_WIDTH-1:0] r_hold_val;
  logic [ID_WIDTH-1:0] r_a_id;
  logic [IN_WIDTH-1:0] r_a_val;
  logic [ID_WIDTH-1:0] r_b_id;
  logic [IN_WIDTH-1:0] r_b_val;
  logic                r_out_valid;
  logic                r_out_last;
  logic                r_err_pad_id;

  logic                w_slot_free;
  logic                w_accept;
  logic                w_load_pair;
  logic                w_store_hold;
  logic [ID_WIDTH-1:0] w_first_id;
  logic [IN_WIDTH-1:0] w_first_val;
  logic [ID_WIDTH-1:0] w_second_id;
  logic [IN_WIDTH-1:0] w_second_val;
  logic [ID_WIDTH-1:0] w_lo_id;
  logic [IN_WIDTH-1:0] w_lo_val;
  logic [ID_WIDTH-1:0] w_hi_id;
  logic [IN_WIDTH-1:0] w_hi_val;

  assign w_slot_free = !r_out_valid || out_ready;
  assign w_accept    = s_valid && w_slot_free;

  always_comb begin
    w_next_state = r_state;
    w_load_pair  = 1'b0;
    w_store_hold = 1'b0;
    case (r_state)
      EMPTY: begin
        if (w_accept) begin
          if (s_last) begin
            w_load_pair = 1'b1;
          end else begin
            w_store_hold = 1'b1;
            w_next_state = HALF;
          end
        end
      end
      HALF: begin
        if (w_accept) begin
          w_load_pair  = 1'b1;
          w_next_state = EMPTY;
        end
      end
      default: w_next_state = EMPTY;
    endcase
  end

  // In EMPTY the partner is the pad, which the sorter keeps on b.
  assign w_first_id   = (r_state == HALF) ? r_hold_id  : s_id;
  assign w_first_val  = (r_state == HALF) ? r_hold_val : s_val;
  assign w_second_id  = (r_state == HALF) ? s_id       : PAD_ID;
  assign w_second_val = (r_state == HALF) ? s_val      : '0;

  spmv_pair_sort #(
    .ID_W  (ID_WIDTH),
    .VAL_W (IN_WIDTH)
  ) u_pair_sort (
    .i_first_id   (w_first_id),
    .i_first_val  (w_first_val),
    .i_second_id  (w_second_id),
    .i_second_val (w_second_val),
    .o_lo_id      (w_lo_id),
    .o_lo_val     (w_lo_val),
    .o_hi_id      (w_hi_id),
    .o_hi_val     (w_hi_val)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= EMPTY;
    end else begin
      r_state <= w_next_state;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_hold_id  <= '0;
      r_hold_val <= '0;
    end else if (w_store_hold) begin
      r_hold_id  <= s_id;
      r_hold_val <= s_val;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_a_id      <= '0;
      r_a_val     <= '0;
      r_b_id      <= '0;
      r_b_val     <= '0;
      r_out_valid <= 1'b0;
      r_out_last  <= 1'b0;
    end else if (w_load_pair) begin
      r_a_id      <= w_lo_id;
      r_a_val     <= w_lo_val;
      r_b_id      <= w_hi_id;
      r_b_val     <= w_hi_val;
      r_out_valid <= 1'b1;
      r_out_last  <= s_last;
    end else if (out_ready) begin
      r_out_valid <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_err_pad_id <= 1'b0;
    end else if (w_accept && (s_id == PAD_ID)) begin
      r_err_pad_id <= 1'b1;
    end
  end

  assign s_ready    = w_slot_free;
  assign a_id       = r_a_id;
  assign a_val      = r_a_val;
  assign b_id       = r_b_id;
  assign b_val      = r_b_val;
  assign out_valid  = r_out_valid;
  assign out_last   = r_out_last;
  assign busy       = (r_state == HALF) || r_out_valid;
  assign err_pad_id = r_err_pad_id;
  assign dbg_state  = r_state;

endmodule

// File: tb/tb_spmv_network_inject.sv
// Bench for spmv_network_inject: directed batches plus randomized traffic,
// checked every cycle against a queue-based pairing model.
module tb_spmv_network_inject;
  import spmv_pkg::*;

  localparam int IW = DEF_IN_WIDTH;
  localparam int DW = DEF_ID_WIDTH;
  localparam logic [DW-1:0] PAD = DEF_PAD_ID;

  typedef struct packed {
    elem_t a;
    elem_t b;
    logic  last;
  } pair_t;

  // clock / reset
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic [DW-1:0] s_id = '0;
  logic [IW-1:0] s_val = '0;
  logic          s_last = 1'b0;
  logic          s_valid = 1'b0;
  logic          s_ready;
  logic [DW-1:0] a_id, b_id;
  logic [IW-1:0] a_val, b_val;
  logic          out_valid, out_last;
  logic          out_ready = 1'b1;
  logic          busy, err_pad_id;
  state_e        dbg_state;

  spmv_network_inject dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .s_id       (s_id),
    .s_val      (s_val),
    .s_last     (s_last),
    .s_valid    (s_valid),
    .s_ready    (s_ready),
    .a_id       (a_id),
    .a_val      (a_val),
    .b_id       (b_id),
    .b_val      (b_val),
    .out_valid  (out_valid),
    .out_last   (out_last),
    .out_ready  (out_ready),
    .busy       (busy),
    .err_pad_id (err_pad_id),
    .dbg_state  (dbg_state)
  );

  int n_vec = 0;
  int n_err = 0;
  logic chk_en = 1'b0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // behavioural model: elements gather into batches of two, pad closes odd batches
  elem_t pend[$];
  pair_t exp_q[$];
  pair_t m_pair;
  logic  m_valid = 1'b0;
  logic  m_err = 1'b0;
  logic  m_acc = 1'b0;
  int    n_pres = 0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pend.delete();
      m_valid = 1'b0;
      m_err   = 1'b0;
      m_acc   = 1'b0;
    end else begin
      elem_t e0, e1;
      m_acc = s_valid && (!m_valid || out_ready);
      if (m_valid && out_ready) begin
        m_valid = 1'b0;
        n_pres++;
      end
      if (m_acc) begin
        if (s_id == PAD) m_err = 1'b1;
        pend.push_back('{id: s_id, val: s_val});
        if (pend.size() == 2 || s_last) begin
          e0 = pend[0];
          e1 = (pend.size() > 1) ? pend[1] : '{id: PAD, val: '0};
          m_pair.a    = (e1.id < e0.id) ? e1 : e0;
          m_pair.b    = (e1.id < e0.id) ? e0 : e1;
          m_pair.last = s_last;
          m_valid     = 1'b1;
          exp_q.push_back(m_pair);
          pend.delete();
        end
      end
    end
  end

  // compare process, sampled mid-cycle
  always @(negedge clk) begin
    if (rst_n && chk_en) begin
      chk("s_ready", s_ready, !m_valid || out_ready);
      chk("out_valid", out_valid, m_valid);
      chk("busy", busy, m_valid || pend.size() != 0);
      chk("err_pad_id", err_pad_id, m_err);
      chk("state", dbg_state, (pend.size() == 1) ? HALF : EMPTY);
      if (m_valid) begin
        chk("a_id", a_id, m_pair.a.id);
        chk("a_val", a_val, m_pair.a.val);
        chk("b_id", b_id, m_pair.b.id);
        chk("b_val", b_val, m_pair.b.val);
        chk("out_last", out_last, m_pair.last);
      end
    end
  end

  // driver tasks (called at posedge+1 or later, off the edge)
  task automatic send(input logic [DW-1:0] id, input logic [IW-1:0] val, input logic last);
    int t;
    s_valid = 1'b1;
    s_id    = id;
    s_val   = val;
    s_last  = last;
    t = 0;
    do begin
      @(posedge clk);
      #1;
      t++;
    end while (!m_acc && t < 50);
    chk("send_accept_timeout", m_acc, 1'b1);
  endtask

  task automatic idle(input int n);
    s_valid = 1'b0;
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic chk_pair(input string nm, input int idx, input logic [DW-1:0] ai,
                          input logic [IW-1:0] av, input logic [DW-1:0] bi,
                          input logic [IW-1:0] bv, input logic lst);
    pair_t p;
    if (idx >= exp_q.size()) begin
      chk({nm, "_missing"}, exp_q.size(), idx + 1);
    end else begin
      p = exp_q[idx];
      chk({nm, "_a_id"}, p.a.id, ai);
      chk({nm, "_a_val"}, p.a.val, av);
      chk({nm, "_b_id"}, p.b.id, bi);
      chk({nm, "_b_val"}, p.b.val, bv);
      chk({nm, "_last"}, p.last, lst);
    end
  endtask

  task automatic pulse_reset();
    #1 rst_n = 1'b0;
    #1;
    chk("rst_out_valid", out_valid, 1'b0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_state", dbg_state, EMPTY);
    chk("rst_a_id", a_id, '0);
    chk("rst_b_val", b_val, '0);
    chk("rst_err", err_pad_id, 1'b0);
    s_valid = 1'b0;
    @(posedge clk);
    #2 rst_n = 1'b1;
    #1;
  endtask

  int base;

  initial begin
    #23 rst_n = 1'b1;
    @(posedge clk);
    #1 chk_en = 1'b1;

    // ids 5,3 -> (3,20)(5,10)
    base = exp_q.size();
    send(5, 10, 1'b0);
    send(3, 20, 1'b1);
    idle(2);
    chk_pair("t_swap", base, 3, 20, 5, 10, 1'b1);

    // single last element in EMPTY -> padded pair
    base = exp_q.size();
    send(7, 9, 1'b1);
    idle(2);
    chk_pair("t_pad", base, 7, 9, PAD, 0, 1'b1);

    // equal ids keep arrival order
    base = exp_q.size();
    send(4, 1, 1'b0);
    send(4, 2, 1'b1);
    idle(2);
    chk_pair("t_tie", base, 4, 1, 4, 2, 1'b1);

    // six back-to-back with a 3-cycle stall after the first pair
    base = exp_q.size();
    fork
      begin
        send(9, 1, 1'b0);
        send(2, 2, 1'b0);
        send(6, 3, 1'b0);
        send(6, 4, 1'b0);
        send(8, 5, 1'b0);
        send(1, 6, 1'b1);
        idle(1);
      end
      begin
        int t;
        t = 0;
        while (exp_q.size() <= base && t < 50) begin
          @(posedge clk);
          t++;
        end
        chk("stall_wait_timeout", exp_q.size() > base, 1'b1);
        #1 out_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1 out_ready = 1'b1;
      end
    join
    idle(3);
    chk("t_b2b_count", exp_q.size() - base, 3);
    chk_pair("t_b2b0", base, 2, 2, 9, 1, 1'b0);
    chk_pair("t_b2b1", base + 1, 6, 3, 6, 4, 1'b0);
    chk_pair("t_b2b2", base + 2, 1, 6, 8, 5, 1'b1);

    // pad id on input sets the sticky error
    base = exp_q.size();
    send(PAD, 7, 1'b1);
    idle(1);
    chk("t_err_set", err_pad_id, 1'b1);
    send(12, 3, 1'b0);
    send(11, 4, 1'b1);
    idle(2);
    chk("t_err_sticky", err_pad_id, 1'b1);
    chk_pair("t_err_pair", base, PAD, 7, PAD, 0, 1'b1);

    // reset while half a pair is held
    send(10, 1, 1'b0);
    idle(0);
    chk("t_half_busy", busy, 1'b1);
    pulse_reset();
    // reset with a pair pending under backpressure
    out_ready = 1'b0;
    send(1, 1, 1'b1);
    idle(1);
    pulse_reset();
    out_ready = 1'b1;
    base = exp_q.size();
    send(20, 5, 1'b0);
    send(21, 6, 1'b1);
    idle(2);
    chk_pair("t_after_rst", base, 20, 5, 21, 6, 1'b1);

    // randomized traffic
    for (int c = 0; c < 600; c++) begin
      if (!s_valid || m_acc) begin
        s_valid = ($urandom_range(0, 9) < 7);
        s_id    = ($urandom_range(0, 19) == 0) ? PAD : DW'($urandom_range(0, 15));
        s_val   = {$urandom(), $urandom()};
        s_last  = ($urandom_range(0, 3) == 0);
      end
      out_ready = ($urandom_range(0, 3) != 0);
      @(posedge clk);
      #1;
    end
    s_valid = 1'b0;
    out_ready = 1'b1;
    idle(4);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/spmv_network_inject.md
Name: spmv_network_inject

Overview:
Ingress stage of the SpMV reduction network. It takes a single stream of (row id, partial product) elements from a multiplier lane and packs them into id-ordered pairs. Each pair is driven onto the a/b sides of one network node input, with one shared valid and one shared ready. It is the transmitter feeding spmv_network_op. Odd-length batches are completed with a pad element.

Parameters:
IN_WIDTH, 59, width of partial-product value
ID_WIDTH, 13, width of row id
PAD_ID, {ID_WIDTH{1'b1}}, reserved id used for pad elements; sorts last

Ports:
clk  input  1  clock
rst_n  input  1  asynchronous active-low reset
s_id  input  ID_WIDTH  incoming element row id
s_val  input  IN_WIDTH  incoming element value
s_last  input  1  element is the final one of a batch
s_valid  input  1  incoming element valid
s_ready  output  1  block can accept an element
a_id  output  ID_WIDTH  lower-id element of pair
a_val  output  IN_WIDTH  lower-id element value
b_id  output  ID_WIDTH  higher-id element of pair
b_val  output  IN_WIDTH  higher-id element value
out_valid  output  1  pair valid (shared by a and b)
out_last  output  1  pair closes the batch
out_ready  input  1  network accepts pair
busy  output  1  element held or pair pending
err_pad_id  output  1  sticky: an input carried id == PAD_ID

Behaviour:
- Reset (async, rst_n low):
  - out_valid=0, out_last=0, busy=0, err_pad_id=0.
  - a_id/a_val/b_id/b_val=0.
  - FSM returns to EMPTY and the hold register is discarded.
  - Reset mid-batch drops the partial pair; no pad is emitted.
- Accept and present:
  - accept = s_valid && s_ready.
  - present = out_valid && out_ready.
- Output slot is a single register. slot_free = !out_valid || out_ready.
- s_ready = slot_free, independent of FSM state and of s_last. There is no combinational path from s_* to a/b outputs.
- FSM states:
  - EMPTY: no element held.
    - accept with !s_last: store element in hold register, go to HALF.
    - accept with s_last: load output with (element, pad) where pad = {PAD_ID, 0}; out_last=1; stay EMPTY.
  - HALF: one element held.
    - accept: load output with hold element and new element, ordered; out_last=s_last; go to EMPTY.
- Ordering:
  - a_id <= b_id (unsigned compare).
  - On equal ids, the earlier-arrived element goes on a.
  - Pad is always on b.
- Latency: out_valid rises the cycle after the accept that completes a pair.
- Backpressure: output fields are held stable while out_valid && !out_ready.
- Simultaneous events: a present and an accept in the same cycle load the new pair back-to-back.
- Throughput:
  - One element per cycle sustained, so one pair every 2 cycles.
  - A last-in-EMPTY element produces a pair in 1 cycle.
- busy = (state==HALF) || out_valid.
- err_pad_id is set on any accept with s_id==PAD_ID. The element is still processed. The flag clears only on reset.
- Widths: values pass through unmodified. The pad value is zero-extended 0.

Decomposition:
- spmv_pkg holds:
  - the pair struct typedef (id, val) parameterised via localparams;
  - the PAD_ID default constant;
  - the FSM state enum {EMPTY, HALF}.
- One sub-module: spmv_pair_sort, a combinational 2-element id compare/swap with tie-keeps-order. It is reusable by the network nodes.

Test Plan:
- Stream ids 5,3 (vals 10,20), last on 3, out_ready=1 → one pair a=(3,20), b=(5,10), out_last=1, one cycle after second accept.
- Single element id 7 val 9 with s_last, in EMPTY → a=(7,9), b=(PAD_ID,0), out_last=1; state stays EMPTY.
- Equal ids 4,4 (vals 1,2) → a=(4,1), b=(4,2).
- Six elements back-to-back, out_ready held low 3 cycles after first pair → s_ready low while stalled; outputs stable; all 3 pairs emitted in order; no loss or duplication.
- Input id = all-ones → err_pad_id goes high and stays high across later batches until rst_n pulse.
- Assert rst_n low while in HALF with a pair pending → out_valid=0, busy=0 immediately; next element after reset starts a fresh pair.
